// File: rtl/uart_pkg.sv
// Shared UART constants and drain-state encoding for the serial demo.
package uart_pkg;

    localparam int unsigned CLK_FREQ = 25_000_000;
    localparam int unsigned BAUD     = 115_200;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with occupancy count, sticky overflow and a
// combinational head output for show-ahead reads.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] head_c,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // A write while full is dropped even if a pop happens in the same cycle.
    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;
    assign head_c = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte-buffered feeder for uart_tx: FIFO plus a drain FSM issuing one
// tx_start pulse per byte and pacing itself on tx_busy.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    drain_state_t      state_q;
    drain_state_t      state_d;
    logic              tx_start_d;
    logic [BYTE_W-1:0] tx_data_d;
    logic              pop_c;
    logic [BYTE_W-1:0] head_c;

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (pop_c),
        .head_c   (head_c),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    // Drain FSM state and registered serializer handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state_q  <= state_d;
            tx_start <= tx_start_d;
            tx_data  <= tx_data_d;
        end
    end

    // Next state: pop head when serializer idle, then wait for busy to rise and fall.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data;
        pop_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_busy) begin
                    tx_data_d  = head_c;
                    tx_start_d = 1'b1;
                    pop_c      = 1'b1;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
